// File: rtl/sabertooth_pkg.sv
// Shared definitions for the Sabertooth packetized-serial receive path:
// command codes, address range, state encodings and the packet checksum.
package sabertooth_pkg;

    localparam logic [6:0] CMD_M1_FWD = 7'd0;
    localparam logic [6:0] CMD_M1_REV = 7'd1;
    localparam logic [6:0] CMD_M2_FWD = 7'd4;
    localparam logic [6:0] CMD_M2_REV = 7'd5;

    localparam int ADDR_MIN = 128;
    localparam int ADDR_MAX = 135;

    typedef enum logic [1:0] {
        WAIT_ADDR,
        GOT_ADDR,
        GOT_CMD,
        GOT_DATA
    } parser_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Packet checksum: low seven bits of address + command + data.
    function automatic logic [6:0] checksum(input logic [7:0] addr,
                                            input logic [6:0] cmd,
                                            input logic [6:0] data);
        logic [7:0] sum;
        sum = addr + {1'b0, cmd} + {1'b0, data};
        return sum[6:0];
    endfunction

endpackage

// File: rtl/sabertooth_rx_decoder_uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer plus a start/data/stop bit engine.
// Emits a one-cycle byte_valid with the byte, or a one-cycle frame_err when
// the stop bit samples low. Reusable for other serial receive paths.
module uart_rx_core
    import sabertooth_pkg::*;
#(
    parameter int DIV = 5208
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    // [0] first flop, [1] synchronized line, [2] previous synchronized value
    logic [2:0]    sync_reg;
    rx_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;

    logic synced;
    logic fall;

    assign synced = sync_reg[1];
    assign fall   = sync_reg[2] & ~sync_reg[1];

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg <= 3'b111;
        end else begin
            sync_reg <= {sync_reg[1:0], uart_in};
        end
    end

    // Bit engine: find the start edge, verify it mid-bit, then sample the
    // eight data bits and the stop bit one bit period apart.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            frame_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (fall) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == CW'(HALF - 1)) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        // A line already back high is a glitch, not a start bit.
                        state_reg   <= synced ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == CW'(DIV - 1)) begin
                        cnt_reg   <= '0;
                        shift_reg <= {synced, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == CW'(DIV - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        if (synced) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sabertooth_rx_decoder.sv
// Sabertooth packetized-serial receiver: parses address/command/data/checksum
// packets from the UART byte stream and publishes decoded motor commands.
module sabertooth_rx_decoder
    import sabertooth_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int BAUD          = 9600,
    parameter int ADDR          = 128,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_in,
    output logic       cmd_valid,
    output logic [6:0] cmd_code,
    output logic [6:0] cmd_data,
    output logic [7:0] m1_speed,
    output logic [7:0] m2_speed,
    output logic       chk_err,
    output logic       frame_err
);

    localparam int DIV            = CLK_HZ / BAUD;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * DIV;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] ADDR_BYTE = 8'(ADDR);

    logic          byte_valid;
    logic [7:0]    byte_data;
    parser_state_t pstate_reg;
    logic [6:0]    cmd_reg;
    logic [6:0]    data_reg;
    logic [TW-1:0] timer_reg;

    uart_rx_core #(
        .DIV(DIV)
    ) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .uart_in   (uart_in),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // Packet parser with resync on address-like bytes, inter-byte timeout,
    // checksum validation and speed register update on acceptance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pstate_reg <= WAIT_ADDR;
            cmd_reg    <= '0;
            data_reg   <= '0;
            timer_reg  <= '0;
            cmd_valid  <= 1'b0;
            chk_err    <= 1'b0;
            cmd_code   <= '0;
            cmd_data   <= '0;
            m1_speed   <= '0;
            m2_speed   <= '0;
        end else begin
            cmd_valid <= 1'b0;
            chk_err   <= 1'b0;
            if (frame_err) begin
                // A corrupted byte invalidates any packet in progress.
                pstate_reg <= WAIT_ADDR;
                timer_reg  <= '0;
            end else if (byte_valid) begin
                timer_reg <= '0;
                if (pstate_reg != WAIT_ADDR && byte_data[7]) begin
                    // Only address bytes have bit 7 set: restart the packet.
                    pstate_reg <= (byte_data == ADDR_BYTE) ? GOT_ADDR : WAIT_ADDR;
                end else begin
                    case (pstate_reg)
                        WAIT_ADDR: begin
                            if (byte_data == ADDR_BYTE) begin
                                pstate_reg <= GOT_ADDR;
                            end
                        end
                        GOT_ADDR: begin
                            cmd_reg    <= byte_data[6:0];
                            pstate_reg <= GOT_CMD;
                        end
                        GOT_CMD: begin
                            data_reg   <= byte_data[6:0];
                            pstate_reg <= GOT_DATA;
                        end
                        GOT_DATA: begin
                            pstate_reg <= WAIT_ADDR;
                            if (byte_data[6:0] == checksum(ADDR_BYTE, cmd_reg, data_reg)) begin
                                cmd_valid <= 1'b1;
                                cmd_code  <= cmd_reg;
                                cmd_data  <= data_reg;
                                case (cmd_reg)
                                    CMD_M1_FWD: m1_speed <= {1'b0, data_reg};
                                    CMD_M1_REV: m1_speed <= 8'd0 - {1'b0, data_reg};
                                    CMD_M2_FWD: m2_speed <= {1'b0, data_reg};
                                    CMD_M2_REV: m2_speed <= 8'd0 - {1'b0, data_reg};
                                    default: ;
                                endcase
                            end else begin
                                chk_err <= 1'b1;
                            end
                        end
                        default: pstate_reg <= WAIT_ADDR;
                    endcase
                end
            end else if (pstate_reg != WAIT_ADDR) begin
                if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    pstate_reg <= WAIT_ADDR;
                    timer_reg  <= '0;
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sabertooth_rx_decoder.sv
// Bench for sabertooth_rx_decoder: serial bytes driven bit by bit, outputs
// compared against a packet-level model of the protocol rules.
module tb_sabertooth_rx_decoder;

    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int ADDR   = 128;
    localparam int TBYTES = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_in = 1'b1;
    logic       cmd_valid;
    logic [6:0] cmd_code;
    logic [6:0] cmd_data;
    logic [7:0] m1_speed;
    logic [7:0] m2_speed;
    logic       chk_err;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    // observed pulse-cycle counts
    int n_cmd = 0, n_chk = 0, n_frame = 0, n_both = 0;

    // model state
    logic [7:0] pkt_q[$];
    int         exp_cmd = 0, exp_chk = 0, exp_frame = 0;
    logic [6:0] exp_code = '0, exp_data = '0;
    logic [7:0] exp_m1 = '0, exp_m2 = '0;

    sabertooth_rx_decoder #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .ADDR(ADDR),
        .TIMEOUT_BYTES(TBYTES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .uart_in(uart_in),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .cmd_data(cmd_data),
        .m1_speed(m1_speed),
        .m2_speed(m2_speed),
        .chk_err(chk_err),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count every cycle each pulse output is high; a stretched pulse shows as
    // an extra count.
    always @(negedge clk) begin
        if (cmd_valid) n_cmd++;
        if (chk_err) n_chk++;
        if (frame_err) n_frame++;
        if (cmd_valid && chk_err) n_both++;
    end

    // Packet-level protocol model fed one received byte at a time.
    task automatic model_byte(input logic [7:0] b);
        int c, d, k;
        if (b[7]) begin
            pkt_q.delete();
            if (int'(b) == ADDR) pkt_q.push_back(b);
        end else if (pkt_q.size() != 0) begin
            pkt_q.push_back(b);
            if (pkt_q.size() == 4) begin
                c = int'(pkt_q[1]);
                d = int'(pkt_q[2]);
                k = int'(pkt_q[3]);
                if ((ADDR + c + d) % 128 == k) begin
                    exp_cmd++;
                    exp_code = 7'(c);
                    exp_data = 7'(d);
                    if (c == 0) exp_m1 = 8'(d);
                    if (c == 1) exp_m1 = 8'(256 - d);
                    if (c == 4) exp_m2 = 8'(d);
                    if (c == 5) exp_m2 = 8'(256 - d);
                end else begin
                    exp_chk++;
                end
                pkt_q.delete();
            end
        end
    endtask

    task automatic model_reset();
        pkt_q.delete();
        exp_code = '0;
        exp_data = '0;
        exp_m1   = '0;
        exp_m2   = '0;
    endtask

    task automatic wait_bits(input int nbits);
        repeat (nbits * DIV) @(negedge clk);
    endtask

    // One 8N1 frame; a low stop bit is followed by one idle bit so the line
    // returns high before the next start edge.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_in = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            wait_bits(1);
        end
        uart_in = stop_ok;
        wait_bits(1);
        uart_in = 1'b1;
        if (!stop_ok) begin
            wait_bits(1);
            pkt_q.delete();
            exp_frame++;
        end else begin
            model_byte(b);
        end
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] k);
        send_byte(a, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d, 1'b1);
        send_byte(k, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_checks++;
        if ({cmd_valid, chk_err, frame_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b want 000", {cmd_valid, chk_err, frame_err});
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({cmd_code, cmd_data, m1_speed, m2_speed} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got code=%0h data=%0h m1=%0h m2=%0h want all 0",
                     cmd_code, cmd_data, m1_speed, m2_speed);
        end
    endtask

    task automatic test_m1_fwd();
        send_pkt(8'h80, 8'h00, 8'h40, 8'h40);
        $display("m1_fwd: cmd_valid count %0d code=%0h data=%0h m1=%0h m2=%0h", n_cmd, cmd_code, cmd_data, m1_speed, m2_speed);
        n_checks++;
        if (n_cmd !== exp_cmd || exp_cmd !== 1) begin
            n_fail++;
            $display("FAIL m1_fwd_count: got %0d want %0d", n_cmd, exp_cmd);
        end
        n_checks++;
        if ({cmd_code, cmd_data} !== {7'h00, 7'h40} || {cmd_code, cmd_data} !== {exp_code, exp_data}) begin
            n_fail++;
            $display("FAIL m1_fwd_fields: got %0h/%0h want 0/40", cmd_code, cmd_data);
        end
        n_checks++;
        if (m1_speed !== 8'h40 || m2_speed !== 8'h00) begin
            n_fail++;
            $display("FAIL m1_fwd_speed: got m1=%0h m2=%0h want m1=40 m2=0", m1_speed, m2_speed);
        end
    endtask

    task automatic test_m2_rev();
        send_pkt(8'h80, 8'h05, 8'h20, 8'h25);
        $display("m2_rev: cmd_valid count %0d m1=%0h m2=%0h", n_cmd, m1_speed, m2_speed);
        n_checks++;
        if (n_cmd !== exp_cmd) begin
            n_fail++;
            $display("FAIL m2_rev_count: got %0d want %0d", n_cmd, exp_cmd);
        end
        n_checks++;
        if (m2_speed !== 8'hE0 || m1_speed !== exp_m1) begin
            n_fail++;
            $display("FAIL m2_rev_speed: got m1=%0h m2=%0h want m1=%0h m2=e0", m1_speed, m2_speed, exp_m1);
        end
    endtask

    task automatic test_bad_checksum();
        send_pkt(8'h80, 8'h00, 8'h10, 8'h11);
        $display("bad_checksum: chk_err count %0d cmd count %0d m1=%0h", n_chk, n_cmd, m1_speed);
        n_checks++;
        if (n_chk !== exp_chk || exp_chk !== 1) begin
            n_fail++;
            $display("FAIL bad_chk_count: got %0d want %0d", n_chk, exp_chk);
        end
        n_checks++;
        if (n_cmd !== exp_cmd || m1_speed !== exp_m1 || cmd_data !== exp_data) begin
            n_fail++;
            $display("FAIL bad_chk_regs: got cmds=%0d m1=%0h data=%0h want cmds=%0d m1=%0h data=%0h",
                     n_cmd, m1_speed, cmd_data, exp_cmd, exp_m1, exp_data);
        end
    endtask

    task automatic test_resync();
        int cmd0, chk0;
        cmd0 = n_cmd;
        chk0 = n_chk;
        send_pkt(8'h81, 8'h00, 8'h40, 8'h41);
        n_checks++;
        if (n_cmd !== cmd0 || n_chk !== chk0) begin
            n_fail++;
            $display("FAIL wrong_addr: got cmd+%0d chk+%0d want 0/0", n_cmd - cmd0, n_chk - chk0);
        end
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h40, 1'b1);
        send_pkt(8'h80, 8'h04, 8'h7F, 8'h03);
        $display("resync: cmd +%0d chk +%0d m2=%0h", n_cmd - cmd0, n_chk - chk0, m2_speed);
        n_checks++;
        if (n_cmd !== cmd0 + 1 || n_chk !== chk0 || n_cmd !== exp_cmd) begin
            n_fail++;
            $display("FAIL resync_counts: got cmd+%0d chk+%0d want 1/0", n_cmd - cmd0, n_chk - chk0);
        end
        n_checks++;
        if (m2_speed !== 8'h7F || cmd_code !== 7'h04) begin
            n_fail++;
            $display("FAIL resync_m2: got m2=%0h code=%0h want 7f/4", m2_speed, cmd_code);
        end
    endtask

    task automatic test_frame_err();
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h40, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_frame !== exp_frame || exp_frame !== 1) begin
            n_fail++;
            $display("FAIL frame_err_count: got %0d want %0d", n_frame, exp_frame);
        end
        send_pkt(8'h80, 8'h01, 8'h7F, 8'h00);
        $display("frame_err: frame count %0d m1=%0h", n_frame, m1_speed);
        n_checks++;
        if (m1_speed !== 8'h81 || n_cmd !== exp_cmd || n_chk !== exp_chk) begin
            n_fail++;
            $display("FAIL frame_recover: got m1=%0h cmds=%0d chks=%0d want 81/%0d/%0d",
                     m1_speed, n_cmd, n_chk, exp_cmd, exp_chk);
        end
    endtask

    task automatic test_timeout();
        int cmd0;
        cmd0 = n_cmd;
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_bits(TBYTES * 10 + 1);
        pkt_q.delete();
        send_byte(8'h40, 1'b1);
        send_byte(8'h40, 1'b1);
        repeat (3) @(negedge clk);
        $display("timeout: cmd +%0d chk count %0d", n_cmd - cmd0, n_chk);
        n_checks++;
        if (n_cmd !== cmd0 || n_chk !== exp_chk) begin
            n_fail++;
            $display("FAIL timeout_resync: got cmd+%0d chks=%0d want 0/%0d", n_cmd - cmd0, n_chk, exp_chk);
        end
        // Gaps of two byte-times stay inside the timeout window.
        send_byte(8'h80, 1'b1);
        wait_bits(20);
        send_byte(8'h04, 1'b1);
        wait_bits(20);
        send_byte(8'h11, 1'b1);
        wait_bits(20);
        send_byte(8'h15, 1'b1);
        repeat (3) @(negedge clk);
        $display("slow_packet: cmd +%0d m2=%0h", n_cmd - cmd0, m2_speed);
        n_checks++;
        if (n_cmd !== cmd0 + 1 || m2_speed !== 8'h11) begin
            n_fail++;
            $display("FAIL slow_packet: got cmd+%0d m2=%0h want 1/11", n_cmd - cmd0, m2_speed);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 24; p++) begin
            logic [7:0] a, c, d, k;
            int kind;
            kind = int'($urandom_range(0, 9));
            a = 8'(ADDR);
            case ($urandom_range(0, 4))
                0: c = 8'd0;
                1: c = 8'd1;
                2: c = 8'd4;
                3: c = 8'd5;
                default: c = 8'($urandom_range(0, 127));
            endcase
            d = 8'($urandom_range(0, 127));
            k = 8'((ADDR + int'(c) + int'(d)) % 128);
            if (kind == 0) k = 8'($urandom_range(0, 127));
            if (kind == 1) a = 8'($urandom_range(129, 135));
            if (kind == 2) send_byte(8'($urandom_range(0, 255)), 1'b1);
            send_pkt(a, c, d, k);
            $display("random %0d: pkt %h %h %h %h cmds=%0d chks=%0d m1=%0h m2=%0h",
                     p, a, c, d, k, n_cmd, n_chk, m1_speed, m2_speed);
            n_checks++;
            if (n_cmd !== exp_cmd || n_chk !== exp_chk) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", p, n_cmd, n_chk, exp_cmd, exp_chk);
            end
            n_checks++;
            if ({cmd_code, cmd_data} !== {exp_code, exp_data}) begin
                n_fail++;
                $display("FAIL rand_fields[%0d]: got %0h/%0h want %0h/%0h", p, cmd_code, cmd_data, exp_code, exp_data);
            end
            n_checks++;
            if (m1_speed !== exp_m1 || m2_speed !== exp_m2) begin
                n_fail++;
                $display("FAIL rand_speed[%0d]: got %0h/%0h want %0h/%0h", p, m1_speed, m2_speed, exp_m1, exp_m2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cmd0;
        send_pkt(8'h80, 8'h00, 8'h33, 8'h33);
        n_checks++;
        if (m1_speed !== 8'h33) begin
            n_fail++;
            $display("FAIL pre_reset_m1: got %0h want 33", m1_speed);
        end
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b1);
        uart_in = 1'b0;
        wait_bits(1);
        uart_in = 1'b1;
        wait_bits(2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        $display("reset_mid: code=%0h data=%0h m1=%0h m2=%0h", cmd_code, cmd_data, m1_speed, m2_speed);
        n_checks++;
        if ({cmd_valid, chk_err, frame_err, cmd_code, cmd_data, m1_speed, m2_speed} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got code=%0h data=%0h m1=%0h m2=%0h want all 0",
                     cmd_code, cmd_data, m1_speed, m2_speed);
        end
        wait_bits(8);
        cmd0 = n_cmd;
        send_byte(8'h40, 1'b1);
        send_byte(8'h40, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_cmd !== cmd0) begin
            n_fail++;
            $display("FAIL reset_mid_parser: got cmd+%0d want 0", n_cmd - cmd0);
        end
        send_pkt(8'h80, 8'h04, 8'h22, 8'h26);
        n_checks++;
        if (m2_speed !== 8'h22 || m1_speed !== 8'h00 || n_cmd !== cmd0 + 1) begin
            n_fail++;
            $display("FAIL reset_mid_next: got m1=%0h m2=%0h cmd+%0d want 0/22/1",
                     m1_speed, m2_speed, n_cmd - cmd0);
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (n_both !== 0) begin
            n_fail++;
            $display("FAIL cmd_chk_overlap: got %0d cycles want 0", n_both);
        end
        n_checks++;
        if (n_frame !== exp_frame || n_chk !== exp_chk || n_cmd !== exp_cmd) begin
            n_fail++;
            $display("FAIL final_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
                     n_cmd, n_chk, n_frame, exp_cmd, exp_chk, exp_frame);
        end
    endtask

    initial begin
        test_reset();
        test_m1_fwd();
        test_m2_rev();
        test_bad_checksum();
        test_resync();
        test_frame_err();
        test_timeout();
        test_random();
        test_reset_mid();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
